// File: rtl/alu_disp_pkg.sv
// ---------------------------------------------------------------------------
// alu_disp_pkg
// Shared definitions for the ALU result display back-end:
//   - state_t       : converter FSM states (IDLE, CONV)
//   - SEG_*         : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   - SEG_BLANK     : all segments off
//   - CONV_ITERS    : shift-and-add-3 iterations for a 5-bit binary input
//   - BIN_W/BCD_W/SHIFT_W : widths of the double-dabble shift register
// ---------------------------------------------------------------------------
package alu_disp_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int CONV_ITERS = 5;
  localparam int BIN_W      = 5;
  localparam int BCD_W      = 8;
  localparam int SHIFT_W    = BCD_W + BIN_W;

endpackage

// File: rtl/alu_result_display_seg7_encode.sv
// ---------------------------------------------------------------------------
// seg7_encode
// Combinational BCD digit to active-low 7-segment pattern.
// Ports:
//   digit [3:0] in  : BCD digit 0..9 (codes 10..15 render blank)
//   blank       in  : force all segments off
//   seg   [6:0] out : {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module seg7_encode
  import alu_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_display.sv
// ---------------------------------------------------------------------------
// alu_result_display
// Accepts a 5-bit ALU result {cout, S[3:0]} over a valid/ready handshake,
// converts it to two BCD digits with an iterative shift-and-add-3 engine
// (one iteration per clock), and drives a time-multiplexed two-digit
// common-anode 7-segment display with leading-zero blanking.
// Ports:
//   clk            in  : system clock, rising edge
//   rst_n          in  : asynchronous active-low reset
//   in_valid       in  : producer has a result on in_value
//   in_value [4:0] in  : unsigned result 0..31
//   in_ready       out : high in IDLE; transfer when in_valid & in_ready
//   busy           out : high while converting
//   seg      [6:0] out : active-low segments {g,f,e,d,c,b,a}, registered
//   an       [1:0] out : active-low digit enables, an[0]=ones, an[1]=tens
// Parameter:
//   REFRESH_CYCLES : cycles each digit stays enabled (>= 2)
// ---------------------------------------------------------------------------
module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [4:0] in_value,
  output logic       in_ready,
  output logic       busy,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CNT_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

  // converter
  state_t               state_reg;
  logic [SHIFT_W-1:0]   shift_reg;
  logic [2:0]           iter_reg;
  logic [BCD_W-1:0]     bcd_adj;
  logic [SHIFT_W-1:0]   shift_pre;
  logic [SHIFT_W-1:0]   shift_step;
  logic                 last_iter;

  // display data
  logic [3:0] tens_reg, tens_next;
  logic [3:0] ones_reg, ones_next;
  logic       blank_reg, blank_next;

  // refresh mux
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             wrap;
  logic             sel_reg, sel_next;   // 0 = ones digit, 1 = tens digit
  logic [3:0]       digit_next;
  logic             digit_blank_next;
  logic [6:0]       seg_next;
  logic [6:0]       seg_reg;
  logic [1:0]       an_reg;

  // ---------------------------------------------------------------------
  // Double-dabble step: add 3 to any BCD nibble >= 5, then shift left.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < BCD_W / 4; gi++) begin : g_nibble_adj
      assign bcd_adj[gi*4 +: 4] =
        (shift_reg[BIN_W + gi*4 +: 4] >= 4'd5) ?
          shift_reg[BIN_W + gi*4 +: 4] + 4'd3 :
          shift_reg[BIN_W + gi*4 +: 4];
    end
  endgenerate

  assign shift_pre  = {bcd_adj, shift_reg[BIN_W-1:0]};
  assign shift_step = shift_pre << 1;
  assign last_iter  = (state_reg == CONV) && (iter_reg == 3'(CONV_ITERS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      iter_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= {{BCD_W{1'b0}}, in_value};
            iter_reg  <= '0;
            state_reg <= CONV;
          end
        end
        CONV: begin
          shift_reg <= shift_step;
          iter_reg  <= iter_reg + 3'd1;
          if (last_iter) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg == CONV);

  // ---------------------------------------------------------------------
  // Display register. The final step's shifted value is latched directly,
  // so the digits land on the same edge the FSM returns to IDLE.
  // ---------------------------------------------------------------------
  always_comb begin
    tens_next  = tens_reg;
    ones_next  = ones_reg;
    blank_next = blank_reg;
    if (last_iter) begin
      tens_next  = shift_step[SHIFT_W-1 -: 4];
      ones_next  = shift_step[BIN_W +: 4];
      blank_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Refresh counter and digit select; free-running, unaffected by the FSM.
  // ---------------------------------------------------------------------
  assign wrap     = (cnt_reg == CNT_W'(REFRESH_CYCLES - 1));
  assign cnt_next = wrap ? '0 : cnt_reg + CNT_W'(1);
  assign sel_next = wrap ? ~sel_reg : sel_reg;

  // Outputs are encoded from next-state select and data so a display update
  // coinciding with a digit toggle never shows stale data on the new digit.
  assign digit_next       = sel_next ? tens_next : ones_next;
  assign digit_blank_next = blank_next | (sel_next & (tens_next == 4'd0));

  seg7_encode u_seg7_encode (
    .digit (digit_next),
    .blank (digit_blank_next),
    .seg   (seg_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_reg  <= '0;
      ones_reg  <= '0;
      blank_reg <= 1'b1;
      cnt_reg   <= '0;
      sel_reg   <= 1'b0;
      seg_reg   <= SEG_BLANK;
      an_reg    <= 2'b10;
    end else begin
      tens_reg  <= tens_next;
      ones_reg  <= ones_next;
      blank_reg <= blank_next;
      cnt_reg   <= cnt_next;
      sel_reg   <= sel_next;
      seg_reg   <= seg_next;
      an_reg    <= sel_next ? 2'b01 : 2'b10;
    end
  end

  assign seg = seg_reg;
  assign an  = an_reg;

endmodule

// File: tb/tb_alu_result_display.sv
// ---------------------------------------------------------------------------
// tb_alu_result_display
// Scoreboard bench: a monitor pushes each accepted value into a queue and
// pops it when the DUT finishes converting (busy falls). Every cycle the
// displayed digit is compared against a reference computed from the value
// with plain decimal arithmetic and the mux phase derived from cycle count.
// ---------------------------------------------------------------------------
module tb_alu_result_display;

  localparam int RC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [4:0] in_value = '0;
  logic       in_ready;
  logic       busy;
  logic [6:0] seg;
  logic [1:0] an;

  always #5 clk = ~clk;

  alu_result_display #(.REFRESH_CYCLES(RC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_value (in_value),
    .in_ready (in_ready),
    .busy     (busy),
    .seg      (seg),
    .an       (an)
  );

  int errors = 0;
  int checks = 0;

  // edges since reset release; refresh phase follows from it
  int k;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  typedef struct {
    int val;
    int cyc;
  } xfer_t;

  xfer_t sb_q[$];
  xfer_t e_tmp;
  int    xfer_log[$];
  int    upd_log[$];
  bit    shown_valid = 1'b0;
  int    shown_val = 0;
  bit    prev_busy = 1'b0;
  int    sel_exp;

  function automatic logic [6:0] pat(int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg_f(bit valid, int v, int sel);
    if (!valid) return 7'h7F;
    if (sel == 0) return pat(v % 10);
    if (v < 10) return 7'h7F;
    return pat(v / 10);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t k=%0d)", name, act, exp, $time, k);
    end
  endtask

  // ---------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      shown_valid = 1'b0;
      prev_busy   = 1'b0;
      chk("rst_seg", seg, 7'h7F);
      chk("rst_an", an, 2'b10);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
    end else begin
      if (prev_busy && !busy) begin
        chk("update_pending", (sb_q.size() > 0) ? 1 : 0, 1);
        if (sb_q.size() > 0) begin
          e_tmp = sb_q.pop_front();
          chk("latency", k - e_tmp.cyc, 5);
          shown_valid = 1'b1;
          shown_val   = e_tmp.val;
          upd_log.push_back(k);
          $display("update cycle=%0d value=%0d", k, e_tmp.val);
        end
      end
      sel_exp = (k / RC) % 2;
      chk("an", an, (sel_exp != 0) ? 2'b01 : 2'b10);
      chk("seg", seg, exp_seg_f(shown_valid, shown_val, sel_exp));
      chk("busy", busy, (sb_q.size() != 0) ? 1 : 0);
      chk("in_ready", in_ready, (sb_q.size() == 0) ? 1 : 0);
      if (in_valid && in_ready) begin
        e_tmp.val = int'(in_value);
        e_tmp.cyc = k + 1;
        sb_q.push_back(e_tmp);
        xfer_log.push_back(k + 1);
        $display("xfer   cycle=%0d value=%0d", k + 1, in_value);
      end
      prev_busy = busy;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic send(int v, bit hold);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_value = v[4:0];
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    chk("send_accept", got, 1);
    if (got) begin
      @(posedge clk);
      #1;
    end
    if (!hold || !got) in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align_send(int phase, int v);
    for (int i = 0; i < 2 * RC * 2 && (k % (2 * RC)) != phase; i++) begin
      @(posedge clk);
      #1;
    end
    send(v, 1'b0);
    idle(12);
    chk("coincide_edge", (upd_log.size() > 0) ? (upd_log[upd_log.size() - 1] % RC) : -1, 0);
  endtask

  initial begin
    int n0;
    int gap;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(12);                        // blank display, mux alternating

    // directed values including boundaries
    send(19, 1'b0); idle(12);
    send(0,  1'b0); idle(12);
    send(31, 1'b0); idle(12);
    send(10, 1'b0); idle(12);

    // back-pressure: in_valid held across two values
    n0 = xfer_log.size();
    send(7, 1'b1);
    send(25, 1'b0);
    chk("bp_count", xfer_log.size() - n0, 2);
    gap = (xfer_log.size() >= n0 + 2) ? xfer_log[n0 + 1] - xfer_log[n0] : -1;
    chk("bp_gap", gap, 6);
    idle(12);

    // randomized values and gaps
    for (int i = 0; i < 10; i++) begin
      send(int'($urandom_range(0, 31)), 1'b0);
      idle(int'($urandom_range(0, 9)));
    end
    idle(12);

    // reset two cycles into a conversion of 23
    send(23, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(20);

    // display update on the refresh wrap edge, toward each digit
    align_send(2, 28);
    align_send(6, 17);
    align_send(2, 9);

    idle(10);
    chk("queue_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
